// File: rtl/dft_scan_capture_mc.sv
// Multi-channel scan capture: shifts NCH scan-out chains in parallel, packs WORD_W-bit words, queues them {ch,last}.
// Build option: DFT_CAPTURE_STALL_EN makes PUSH wait on a full FIFO instead of dropping words (ovf_err).
module dft_scan_capture_mc #(
    parameter int NCH    = 4,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 8,
    parameter int LEN_W  = 16,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    dft_sin,
    output logic              scan_en,
    input  logic              cmd_val,
    output logic              cmd_rdy,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [NCH-1:0]    cmd_mask,
    output logic              busy,
    output logic              done,
    output logic              ovf_err,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [WORD_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last,
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_PUSH  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam int WC_W  = $clog2(WORD_W + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = CH_W + 1 + WORD_W;

    logic [1:0]        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  tot_q, tot_d;
    logic [NCH-1:0]    mask_q, mask_d;
    logic [NCH-1:0]    pend_q, pend_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [WORD_W-1:0] sreg_q [NCH];
    logic [WORD_W-1:0] sreg_d [NCH];
    logic              ovf_q, ovf_d;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [CH_W-1:0]   sel;
    logic [NCH-1:0]    pend_nx;
    logic              push_req, push_ok, pop, fifo_full, hold, drop;
    logic              push_last;

    // Both ports use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
    assign cmd_rdy     = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign scan_en     = (state_q == S_SHIFT);
    assign done        = (state_q == S_FIN);
    assign ovf_err     = ovf_q;
    assign dbg_state_o = state_q;

    // Lowest pending masked chain is emitted first.
    always_comb begin
        sel = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (pend_q[c]) sel = CH_W'(c);
        end
    end

    assign pend_nx   = pend_q & ~(NCH'(1) << sel);
    assign push_req  = (state_q == S_PUSH) && (pend_q != '0);
    assign pop       = (cnt_q != '0) && out_rdy;
    assign fifo_full = (cnt_q == CNT_W'(DEPTH));
    assign push_ok   = push_req && (!fifo_full || pop);
    assign push_last = (tot_q == len_q);

`ifdef DFT_CAPTURE_STALL_EN
    assign hold = push_req && !push_ok;
    assign drop = 1'b0;
`else
    assign hold = 1'b0;
    assign drop = push_req && !push_ok;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        tot_d   = tot_q;
        mask_d  = mask_q;
        pend_d  = pend_q;
        wcnt_d  = wcnt_q;
        sreg_d  = sreg_q;
        ovf_d   = ovf_q | drop;
        case (state_q)
            S_IDLE: begin
                if (cmd_val) begin
                    len_d   = cmd_len;
                    mask_d  = cmd_mask;
                    tot_d   = '0;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                    for (int c = 0; c < NCH; c++) sreg_d[c] = '0;
                    state_d = (cmd_len == '0) ? S_FIN : S_SHIFT;
                end
            end
            S_SHIFT: begin
                for (int c = 0; c < NCH; c++) begin
                    sreg_d[c] = {sreg_q[c][WORD_W-2:0], dft_sin[c]};
                end
                wcnt_d = wcnt_q + WC_W'(1);
                tot_d  = tot_q + LEN_W'(1);
                if ((wcnt_d == WC_W'(WORD_W)) || (tot_d == len_q)) begin
                    pend_d  = mask_q;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (!hold) begin
                    pend_d = pend_nx;
                    if (pend_nx == '0) begin
                        for (int c = 0; c < NCH; c++) sreg_d[c] = '0;
                        wcnt_d  = '0;
                        state_d = push_last ? S_FIN : S_SHIFT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            tot_q    <= '0;
            mask_q   <= '0;
            pend_q   <= '0;
            wcnt_q   <= '0;
            ovf_q    <= 1'b0;
            for (int c = 0; c < NCH; c++) sreg_q[c] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            tot_q   <= tot_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
            sreg_q  <= sreg_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (!push_ok && pop) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Storage is not reset; the read side is gated by out_val so stale entries never show.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {sel, push_last, sreg_q[sel]};
    end

    assign out_val = (cnt_q != '0);
    assign {out_ch, out_last, out_data} = out_val ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_dft_scan_capture_mc.sv
// Directed bench for dft_scan_capture_mc: scoreboard of expected {ch,last,data} words, drained by a monitor.
module tb_dft_scan_capture_mc;
    localparam int NCH = 4, W = 32, DEPTH = 8, LEN_W = 16, CH_W = 2;
    localparam int EW = CH_W + 1 + W;

    logic             clk, rst_n;
    logic [NCH-1:0]   dft_sin;
    logic             scan_en, cmd_val, cmd_rdy, busy, done, ovf_err;
    logic [LEN_W-1:0] cmd_len;
    logic [NCH-1:0]   cmd_mask;
    logic             out_val, out_rdy, out_last;
    logic [W-1:0]     out_data;
    logic [CH_W-1:0]  out_ch;
    logic [1:0]       dbg_state;

    dft_scan_capture_mc #(.NCH(NCH), .WORD_W(W), .DEPTH(DEPTH), .LEN_W(LEN_W), .CH_W(CH_W)) dut (
        .clk(clk), .reset(rst_n), .dft_sin(dft_sin), .scan_en(scan_en),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_len(cmd_len), .cmd_mask(cmd_mask),
        .busy(busy), .done(done), .ovf_err(ovf_err),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_ch(out_ch),
        .out_last(out_last), .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   wds [NCH][3];
    int            sidx;
    logic [63:0]   se_hist;
    int            done_cnt = 0;
    int            d0;

    // Each chain streams its words MSB-first, one bit per scan_en cycle since the last accept.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            dft_sin[c] = (sidx < 96) ? wds[c][sidx / 32][31 - (sidx % 32)] : 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sidx    <= 0;
            se_hist <= '0;
        end else if (cmd_val && cmd_rdy) begin
            sidx    <= 0;
            se_hist <= '0;
        end else begin
            if (scan_en) sidx <= sidx + 1;
            se_hist <= {se_hist[62:0], scan_en};
        end
    end

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_val && out_rdy) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL extra_word: observed %0h expected none", {out_ch, out_last, out_data});
            end else begin
                mon_e = exp_q.pop_front();
                check("out_word", 64'({out_ch, out_last, out_data}), 64'(mon_e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input int len, input logic [3:0] mask, input int keep);
        int n;
        n = 0;
        for (int j = 0; j * 32 < len; j++) begin
            for (int c = 0; c < NCH; c++) begin
                if (mask[c]) begin
                    int          nb;
                    logic [31:0] v;
                    logic        lst;
                    nb  = (len - 32 * j >= 32) ? 32 : len - 32 * j;
                    v   = wds[c][j] >> (32 - nb);
                    lst = (32 * j + nb == len);
                    if (n < keep) exp_q.push_back({CH_W'(c), lst, v});
                    n++;
                end
            end
        end
    endtask

    task automatic issue(input int len, input logic [3:0] mask);
        bit acc;
        acc      = 1'b0;
        cmd_len  = LEN_W'(len);
        cmd_mask = mask;
        cmd_val  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_rdy) begin
                acc = 1'b1;
                break;
            end
            tick();
        end
        check("cmd_accept", 64'(acc), 64'd1);
        tick();
        cmd_val = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, 64'(seen), 64'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_out_val_idle"}, 64'(out_val), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_val = 1'b0; cmd_len = '0; cmd_mask = '0; out_rdy = 1'b0;
        for (int c = 0; c < NCH; c++) for (int j = 0; j < 3; j++) wds[c][j] = '0;
        repeat (3) @(negedge clk);
        check("rst_scan_en", 64'(scan_en), 64'd0);
        check("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(ovf_err), 64'd0);
        check("rst_out_val", 64'(out_val), 64'd0);
        check("rst_out_fields", 64'({out_ch, out_last, out_data}), 64'd0);
        tick();
        rst_n = 1'b1;

        // Two masked chains, one full word each.
        wds[0][0] = 32'hA5A5A5A5;
        wds[2][0] = 32'h12345678;
        out_rdy   = 1'b1;
        exp_q.push_back({2'd0, 1'b1, 32'hA5A5A5A5});
        exp_q.push_back({2'd2, 1'b1, 32'h12345678});
        d0 = done_cnt;
        issue(32, 4'b0101);
        wait_done(100, "t1");
        check("t1_scan_en_trace", se_hist, 64'h3_FFFF_FFFC);
        check("t1_scan_bits", 64'(sidx), 64'd32);
        @(negedge clk);
        check("t1_done_one_cycle", 64'(done), 64'd0);
        drain("t1");
        check("t1_done_count", 64'(done_cnt - d0), 64'd1);

        // Full word plus an 8-bit partial word; a busy-time command is ignored.
        wds[0][0] = 32'hDEADBEEF;
        wds[0][1] = 32'hC35A0011;
        exp_q.push_back({2'd0, 1'b0, 32'hDEADBEEF});
        exp_q.push_back({2'd0, 1'b1, 32'h000000C3});
        d0 = done_cnt;
        issue(40, 4'b0001);
        repeat (5) tick();
        cmd_len = '0;
        cmd_val = 1'b1;
        check("t2_busy_cmd_rdy", 64'(cmd_rdy), 64'd0);
        check("t2_busy", 64'(busy), 64'd1);
        tick();
        cmd_val = 1'b0;
        wait_done(100, "t2");
        check("t2_scan_en_trace", se_hist, 64'h0000_03FF_FFFF_FDFE);
        drain("t2");
        check("t2_done_count", 64'(done_cnt - d0), 64'd1);

        // Zero-length command.
        issue(0, 4'hF);
        wait_done(4, "t3");
        check("t3_no_scan", se_hist, 64'd0);
        check("t3_out_val", 64'(out_val), 64'd0);

        // Twelve words against an eight-entry FIFO with the consumer stalled.
        for (int c = 0; c < NCH; c++) for (int j = 0; j < 3; j++) wds[c][j] = $urandom_range(32'hFFFF_FFFF, 0);
        out_rdy = 1'b0;
`ifdef DFT_CAPTURE_STALL_EN
        model(96, 4'hF, 12);
        issue(96, 4'hF);
        repeat (150) @(negedge clk);
        check("t4_stalled_busy", 64'(busy), 64'd1);
        check("t4_stalled_state", 64'(dbg_state), 64'd2);
        check("t4_stalled_ovf", 64'(ovf_err), 64'd0);
        tick();
        out_rdy = 1'b1;
        wait_done(100, "t4");
        check("t4_ovf", 64'(ovf_err), 64'd0);
        drain("t4");
        out_rdy = 1'b0;
`else
        model(96, 4'hF, 8);
        issue(96, 4'hF);
        wait_done(150, "t4");
        check("t4_ovf", 64'(ovf_err), 64'd1);
`endif

        // Pushes while the FIFO is full and popping in the same cycle.
        for (int c = 0; c < NCH; c++) wds[c][0] = $urandom_range(32'hFFFF_FFFF, 0);
        model(32, 4'hF, 4);
        issue(32, 4'hF);
        check("t5_ovf_cleared", 64'(ovf_err), 64'd0);
        for (int i = 0; i < 60; i++) begin
            if (dbg_state == 2'd2) break;
            tick();
        end
        check("t5_reached_push", 64'(dbg_state), 64'd2);
        out_rdy = 1'b1;
        wait_done(40, "t5");
        check("t5_ovf", 64'(ovf_err), 64'd0);
        drain("t5");

        // Reset in the middle of a 64-bit capture, then a clean command.
        wds[0][0] = $urandom_range(32'hFFFF_FFFF, 0);
        wds[0][1] = $urandom_range(32'hFFFF_FFFF, 0);
        out_rdy = 1'b0;
        issue(64, 4'b0001);
        repeat (40) tick();
        check("t6_word_held", 64'(out_val), 64'd1);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_scan_en", 64'(scan_en), 64'd0);
        check("t6_rst_out_val", 64'(out_val), 64'd0);
        check("t6_rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        tick();
        rst_n = 1'b1;
        wds[1][0] = $urandom_range(32'hFFFF_FFFF, 0);
        wds[2][0] = $urandom_range(32'hFFFF_FFFF, 0);
        out_rdy = 1'b1;
        model(32, 4'b0110, 4);
        issue(32, 4'b0110);
        wait_done(100, "t6");
        drain("t6");
        check("t6_done_count", 64'(done_cnt - d0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
